xcvr_link_sequencer: RTL and testbench

//  Bring-up/recovery controller for one 10GBASE-R transceiver PHY wrapper (QPLL + GT + PCS).

---
 rtl/xcvr_link_sequencer_pkg.sv | 34 +++
 rtl/xcvr_link_sequencer_timer.sv | 27 ++
 rtl/xcvr_link_sequencer.sv | 173 +++++++++++++++++
 tb/tb_xcvr_link_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_link_sequencer_pkg.sv
// Shared state encoding and reset-output layout for the transceiver link sequencer.
package xcvr_link_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLL_RST  = 3'd1,
    S_PLL_WAIT = 3'd2,
    S_TX_RST   = 3'd3,
    S_RX_RST   = 3'd4,
    S_RX_WAIT  = 3'd5,
    S_LINK_UP  = 3'd6,
    S_FAULT    = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic qpll;
    logic tx;
    logic rx;
  } rst_vec_t;

  // Reset requests release in dependency order: QPLL first, then TX, then RX.
  function automatic rst_vec_t rst_vec_for(input seq_state_e s);
    rst_vec_t v;
    v = '{qpll: 1'b1, tx: 1'b1, rx: 1'b1};
    case (s)
      S_PLL_WAIT, S_TX_RST: v = '{qpll: 1'b0, tx: 1'b1, rx: 1'b1};
      S_RX_RST:             v = '{qpll: 1'b0, tx: 1'b0, rx: 1'b1};
      S_RX_WAIT, S_LINK_UP: v = '{qpll: 1'b0, tx: 1'b0, rx: 1'b0};
      default:              v = '{qpll: 1'b1, tx: 1'b1, rx: 1'b1};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/xcvr_link_sequencer_timer.sv
// State-residency timer: cleared on state entry, flags when the count equals the supplied limit.
module xcvr_link_seq_timer #(
  parameter int unsigned TIMER_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/xcvr_link_sequencer.sv
// Bring-up/recovery sequencer for a 10GBASE-R PHY (QPLL, TX, RX resets, block-lock qualification).
// Optional XCVR_LINK_SEQ_STATS_EN adds saturating link_drop_count / relock_count outputs.
module xcvr_link_sequencer
  import xcvr_link_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 125000,
  parameter int unsigned BLOCK_TIMEOUT = 1250000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RETRY_MAX     = 8,
  parameter int unsigned TIMER_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        qpll_lock,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  output logic        qpll_reset,
  output logic        tx_reset,
  output logic        rx_reset,
  output logic        link_up,
  output logic        fault,
  output logic [2:0]  state,
  output logic [3:0]  retry_count
`ifdef XCVR_LINK_SEQ_STATS_EN
  ,
  output logic [15:0] link_drop_count,
  output logic [15:0] relock_count
`endif
);

  localparam logic [TIMER_W-1:0] RST_LIM    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LIM   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BLOCK_LIM  = TIMER_W'(BLOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LIM = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_LIM  = 4'(RETRY_MAX);

  seq_state_e         state_q, state_d;
  logic [3:0]         retry_q, retry_d, retry_inc;
  logic [TIMER_W-1:0] good_q;
  logic [TIMER_W-1:0] tmr_limit;
  logic               tmr_clear, tmr_en, tmr_done;
  logic               rx_good, do_retry;
  seq_state_e         retry_tgt;
  rst_vec_t           rst_vec_d;

  assign rx_good   = rx_block_lock & ~rx_high_ber;
  assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
  assign tmr_clear = (state_d != state_q);
  assign tmr_en    = state_q inside {S_PLL_RST, S_PLL_WAIT, S_TX_RST, S_RX_RST, S_RX_WAIT};

  always_comb begin
    case (state_q)
      S_PLL_WAIT: tmr_limit = LOCK_LIM;
      S_RX_WAIT:  tmr_limit = BLOCK_LIM;
      default:    tmr_limit = RST_LIM;
    endcase
  end

  xcvr_link_seq_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(tmr_clear),
    .en   (tmr_en),
    .limit(tmr_limit),
    .done (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  // Retry paths pick a target first; the shared tail below diverts to FAULT when the budget runs out.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    do_retry  = 1'b0;
    retry_tgt = S_PLL_RST;
    if (!enable) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else if (!qpll_lock && (state_q inside {S_TX_RST, S_RX_RST, S_RX_WAIT, S_LINK_UP})) begin
      do_retry  = 1'b1;
      retry_tgt = S_PLL_RST;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_PLL_RST;
        S_PLL_RST:  if (tmr_done) state_d = S_PLL_WAIT;
        S_PLL_WAIT: begin
          if (qpll_lock) begin
            state_d = S_TX_RST;
          end else if (tmr_done) begin
            do_retry  = 1'b1;
            retry_tgt = S_PLL_RST;
          end
        end
        S_TX_RST:   if (tmr_done) state_d = S_RX_RST;
        S_RX_RST:   if (tmr_done) state_d = S_RX_WAIT;
        S_RX_WAIT: begin
          if (rx_good && (good_q == STABLE_LIM)) begin
            state_d = S_LINK_UP;
            retry_d = '0;
          end else if (tmr_done) begin
            do_retry  = 1'b1;
            retry_tgt = S_RX_RST;
          end
        end
        S_LINK_UP:  if (!rx_good) state_d = S_RX_RST;
        S_FAULT:    state_d = S_FAULT;
        default:    state_d = S_IDLE;
      endcase
    end
    if (do_retry) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_LIM) ? S_FAULT : retry_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q <= '0;
    end else if (state_q == S_RX_WAIT && state_d == S_RX_WAIT && rx_good) begin
      good_q <= good_q + 1'b1;
    end else begin
      good_q <= '0;
    end
  end

  assign rst_vec_d = rst_vec_for(state_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qpll_reset <= 1'b1;
      tx_reset   <= 1'b1;
      rx_reset   <= 1'b1;
      link_up    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      qpll_reset <= rst_vec_d.qpll;
      tx_reset   <= rst_vec_d.tx;
      rx_reset   <= rst_vec_d.rx;
      link_up    <= (state_d == S_LINK_UP);
      fault      <= (state_d == S_FAULT);
    end
  end

  assign state       = state_q;
  assign retry_count = retry_q;

`ifdef XCVR_LINK_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_drop_count <= '0;
      relock_count    <= '0;
    end else begin
      if (state_q == S_LINK_UP && state_d == S_RX_RST && link_drop_count != '1)
        link_drop_count <= link_drop_count + 16'd1;
      if (state_q != S_LINK_UP && state_d == S_LINK_UP && relock_count != '1)
        relock_count <= relock_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xcvr_link_sequencer.sv
// Scenario bench for xcvr_link_sequencer; expected per-cycle snapshots go through a scoreboard queue.
module tb_xcvr_link_sequencer;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 50;
  localparam int unsigned BLOCK_TIMEOUT = 200;
  localparam int unsigned STABLE_CYCLES = 10;
  localparam int unsigned RETRY_MAX     = 3;
  localparam int unsigned TIMER_W       = 24;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PLL_RST  = 3'd1;
  localparam logic [2:0] ST_PLL_WAIT = 3'd2;
  localparam logic [2:0] ST_TX_RST   = 3'd3;
  localparam logic [2:0] ST_RX_RST   = 3'd4;
  localparam logic [2:0] ST_RX_WAIT  = 3'd5;
  localparam logic [2:0] ST_LINK_UP  = 3'd6;
  localparam logic [2:0] ST_FAULT    = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       qr;
    logic       tr;
    logic       rr;
    logic       lu;
    logic       ft;
    logic [3:0] rc;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       qpll_lock = 1'b0;
  logic       rx_block_lock = 1'b0;
  logic       rx_high_ber = 1'b0;
  logic       qpll_reset, tx_reset, rx_reset, link_up, fault;
  logic [2:0] state;
  logic [3:0] retry_count;
`ifdef XCVR_LINK_SEQ_STATS_EN
  logic [15:0] link_drop_count, relock_count;
`endif

  int    checks = 0;
  int    failures = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  xcvr_link_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .BLOCK_TIMEOUT(BLOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .RETRY_MAX    (RETRY_MAX),
    .TIMER_W      (TIMER_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .qpll_lock    (qpll_lock),
    .rx_block_lock(rx_block_lock),
    .rx_high_ber  (rx_high_ber),
    .qpll_reset   (qpll_reset),
    .tx_reset     (tx_reset),
    .rx_reset     (rx_reset),
    .link_up      (link_up),
    .fault        (fault),
    .state        (state),
    .retry_count  (retry_count)
`ifdef XCVR_LINK_SEQ_STATS_EN
    ,
    .link_drop_count(link_drop_count),
    .relock_count   (relock_count)
`endif
  );

  // Expected outputs straight from the per-state output table.
  function automatic snap_t exp_of(input logic [2:0] st, input logic [3:0] rc);
    snap_t s;
    s.st = st;
    s.rc = rc;
    s.lu = (st == ST_LINK_UP);
    s.ft = (st == ST_FAULT);
    case (st)
      ST_PLL_WAIT, ST_TX_RST: {s.qr, s.tr, s.rr} = 3'b011;
      ST_RX_RST:              {s.qr, s.tr, s.rr} = 3'b001;
      ST_RX_WAIT, ST_LINK_UP: {s.qr, s.tr, s.rr} = 3'b000;
      default:                {s.qr, s.tr, s.rr} = 3'b111;
    endcase
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s = {state, qpll_reset, tx_reset, rx_reset, link_up, fault, retry_count};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    qpll_lock = 1'b0;
    rx_block_lock = 1'b0;
    rx_high_ber = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Clean bring-up with everything locked: LINK_UP is reached after edge 24.
  task automatic bring_up();
    do_reset();
    enable = 1'b1;
    qpll_lock = 1'b1;
    rx_block_lock = 1'b1;
    repeat (24) tick();
  endtask

  task automatic test_reset();
    snap_t e, got;
    rst = 1'b1;
    enable = 1'b1;
    qpll_lock = 1'b1;
    rx_block_lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(exp_of(ST_IDLE, 4'd0));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset k=%0d got=%03h exp=%03h", k, got, e);
      end
    end
  endtask

  task automatic test_bring_up();
    snap_t e, got;
    logic [2:0] st;
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      if (k == 20) qpll_lock = 1'b1;
      if (k == 40) rx_block_lock = 1'b1;
      if (k < 5)       st = ST_PLL_RST;
      else if (k < 20) st = ST_PLL_WAIT;
      else if (k < 24) st = ST_TX_RST;
      else if (k < 28) st = ST_RX_RST;
      else if (k < 49) st = ST_RX_WAIT;
      else             st = ST_LINK_UP;
      exp_q.push_back(exp_of(st, 4'd0));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL bring_up k=%0d got=%03h exp=%03h", k, got, e);
      end
    end
  endtask

  // PLL_RST lasts 4 cycles, PLL_WAIT 50, so each attempt spans 54 cycles.
  task automatic test_pll_timeout();
    snap_t e, got;
    logic [2:0] st;
    logic [3:0] rc;
    int a, p;
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      if (k >= 163) begin
        st = ST_FAULT;
        rc = 4'd3;
      end else begin
        a = (k - 1) / 54;
        p = (k - 1) % 54;
        st = (p < 4) ? ST_PLL_RST : ST_PLL_WAIT;
        rc = 4'(a);
      end
      exp_q.push_back(exp_of(st, rc));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL pll_timeout k=%0d got=%03h exp=%03h", k, got, e);
      end
    end
  endtask

  task automatic test_fault_exit();
    snap_t e, got;
    qpll_lock = 1'b1;
    rx_block_lock = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) enable = 1'b0;
      exp_q.push_back((k == 5) ? exp_of(ST_IDLE, 4'd0) : exp_of(ST_FAULT, 4'd3));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL fault_exit k=%0d got=%03h exp=%03h", k, got, e);
      end
    end
  endtask

  task automatic test_link_drop();
    snap_t e, got;
    logic [2:0] st;
    bring_up();
    exp_q.push_back(exp_of(ST_LINK_UP, 4'd0));
    e = exp_q.pop_front();
    got = dut_snap();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL link_drop_start got=%03h exp=%03h", got, e);
    end
    for (int j = 1; j <= 36; j++) begin
      if (j == 1)  rx_block_lock = 1'b0;
      if (j == 2)  rx_block_lock = 1'b1;
      if (j == 19) rx_high_ber = 1'b1;
      if (j == 20) rx_high_ber = 1'b0;
      if (j < 5)       st = ST_RX_RST;
      else if (j < 15) st = ST_RX_WAIT;
      else if (j < 19) st = ST_LINK_UP;
      else if (j < 23) st = ST_RX_RST;
      else if (j < 33) st = ST_RX_WAIT;
      else             st = ST_LINK_UP;
      exp_q.push_back(exp_of(st, 4'd0));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL link_drop j=%0d got=%03h exp=%03h", j, got, e);
      end
    end
`ifdef XCVR_LINK_SEQ_STATS_EN
    checks++;
    if (relock_count !== 16'd3 || link_drop_count !== 16'd2) begin
      failures++;
      $display("FAIL stats_after_drops relock=%0d drops=%0d exp relock=3 drops=2",
               relock_count, link_drop_count);
    end
`endif
  endtask

  // Block lock alternates 5 on / 5 off: never 10 consecutive good cycles, so RX_WAIT times out.
  task automatic test_rx_timeout();
    snap_t e, got;
    logic [2:0] st;
    logic [3:0] rc;
    do_reset();
    enable = 1'b1;
    qpll_lock = 1'b1;
    for (int k = 1; k <= 225; k++) begin
      rx_block_lock = ((k / 5) % 2) == 1;
      rc = (k >= 214) ? 4'd1 : 4'd0;
      if (k < 5)        st = ST_PLL_RST;
      else if (k < 6)   st = ST_PLL_WAIT;
      else if (k < 10)  st = ST_TX_RST;
      else if (k < 14)  st = ST_RX_RST;
      else if (k < 214) st = ST_RX_WAIT;
      else if (k < 218) st = ST_RX_RST;
      else              st = ST_RX_WAIT;
      exp_q.push_back(exp_of(st, rc));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rx_timeout k=%0d got=%03h exp=%03h", k, got, e);
      end
    end
  endtask

  task automatic test_qpll_loss();
    snap_t e, got;
    bring_up();
    for (int j = 1; j <= 8; j++) begin
      if (j == 1) qpll_lock = 1'b0;
      exp_q.push_back(exp_of((j < 5) ? ST_PLL_RST : ST_PLL_WAIT, 4'd1));
      tick();
      e = exp_q.pop_front();
      got = dut_snap();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL qpll_loss j=%0d got=%03h exp=%03h", j, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, got;
    bring_up();
    rx_block_lock = 1'b0;
    repeat (8) tick();
    exp_q.push_back(exp_of(ST_RX_WAIT, 4'd0));
    e = exp_q.pop_front();
    got = dut_snap();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL pre_rst_rx_wait got=%03h exp=%03h", got, e);
    end
`ifdef XCVR_LINK_SEQ_STATS_EN
    checks++;
    if (relock_count !== 16'd1 || link_drop_count !== 16'd1) begin
      failures++;
      $display("FAIL stats_pre_rst relock=%0d drops=%0d exp 1/1", relock_count, link_drop_count);
    end
`endif
    #3;
    rst = 1'b1;
    exp_q.push_back(exp_of(ST_IDLE, 4'd0));
    #1;
    e = exp_q.pop_front();
    got = dut_snap();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL async_rst got=%03h exp=%03h", got, e);
    end
`ifdef XCVR_LINK_SEQ_STATS_EN
    checks++;
    if (relock_count !== 16'd0 || link_drop_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_rst relock=%0d drops=%0d exp 0/0", relock_count, link_drop_count);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bring_up();
    test_pll_timeout();
    test_fault_exit();
    test_link_drop();
    test_rx_timeout();
    test_qpll_loss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
